// File: rtl/and_event_monitor_pkg.sv
// Purpose: shared definitions for the AND-gate event monitor: FSM state
//          encodings, default parameter values and a counter-width helper.
// Ports:   none (package).
package and_event_monitor_pkg;

   localparam int unsigned DEF_FILT_LEN = 3;
   localparam int unsigned DEF_CNT_W    = 8;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } state_e;

   // Bits needed to hold 0 .. n-1 (at least one bit).
   function automatic int unsigned stab_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/and_event_monitor_glitch_filter.sv
// Purpose: deglitch filter. q follows d only after d has differed from q on
//          FILT_LEN consecutive clock edges; FILT_LEN=1 is a plain register.
// Ports:   clk, rst (sync, active-high), d (raw input), q (filtered output),
//          q_nxt_c (combinational value q takes at the next edge).
module glitch_filter
   import and_event_monitor_pkg::*;
#(
   parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic q_nxt_c
);

   localparam int unsigned    SW   = stab_w(FILT_LEN);
   localparam logic [SW-1:0]  LAST = SW'(FILT_LEN - 1);

   logic [SW-1:0] r_stab;
   logic          r_q;
   logic          w_flip;

   // The edge on which the differing run reaches FILT_LEN flips the output.
   assign w_flip  = (d != r_q) && (r_stab == LAST);
   assign q_nxt_c = w_flip ? d : r_q;
   assign q       = r_q;

   // Stability counter and filtered output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stab <= '0;
         r_q    <= 1'b0;
      end else begin
         r_q <= q_nxt_c;
         if ((d == r_q) || w_flip) begin
            r_stab <= '0;
         end else begin
            r_stab <= r_stab + SW'(1);
         end
      end
   end

endmodule

// File: rtl/and_event_monitor.sv
// Purpose: monitors the AND-gate output: deglitches it, counts filtered rises
//          and reports each filtered high-period length over valid/ready.
// Ports:   clk, rst (sync, active-high), and_in (raw gate output), en (enable),
//          clr (clears evt_count/sat/ovf), filt_out, evt_pulse, evt_count, sat,
//          rpt_valid, rpt_ready, rpt_data, ovf.
module and_event_monitor
   import and_event_monitor_pkg::*;
#(
   parameter int unsigned FILT_LEN = DEF_FILT_LEN,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             and_in,
   input  logic             en,
   input  logic             clr,
   output logic             filt_out,
   output logic             evt_pulse,
   output logic [CNT_W-1:0] evt_count,
   output logic             sat,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_data,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             w_filt;
   logic             w_filt_nxt;
   state_e           r_state;
   state_e           w_state_nxt;
   logic             w_rise;
   logic             w_fall;
   logic             w_load;
   logic             w_drain;

   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;
   logic             r_armed;
   logic [CNT_W-1:0] r_len;
   logic             r_valid;
   logic [CNT_W-1:0] r_data;
   logic             r_ovf;

   glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk     (clk),
      .rst     (rst),
      .d       (and_in),
      .q       (w_filt),
      .q_nxt_c (w_filt_nxt)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOW;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: follows the filter's upcoming value so that events line
   // up with the first cycle filt_out shows the new level.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOW:  if (w_filt_nxt)  w_state_nxt = ST_HIGH;
         ST_HIGH: if (!w_filt_nxt) w_state_nxt = ST_LOW;
         default: w_state_nxt = ST_LOW;
      endcase
   end

   // FSM edge decode.
   always_comb begin
      w_rise = 1'b0;
      w_fall = 1'b0;
      case (r_state)
         ST_LOW:  w_rise = w_filt_nxt;
         ST_HIGH: w_fall = !w_filt_nxt;
         default: ;
      endcase
   end

   assign w_load  = w_fall && r_armed && en;
   assign w_drain = r_valid && rpt_ready;

   // Event counter, high-period length and report holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
         r_armed <= 1'b0;
         r_len   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_pulse <= w_rise && en;

         if (clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (w_rise && en) begin
            if (r_cnt == CNT_MAX) begin
               r_sat <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         // r_len counts cycles filt_out has been 1, saturating.
         if (w_rise) begin
            r_armed <= en;
            r_len   <= CNT_W'(1);
         end else if ((r_state == ST_HIGH) && w_filt_nxt && (r_len != CNT_MAX)) begin
            r_len <= r_len + CNT_W'(1);
         end

         if (w_load && (!r_valid || w_drain)) begin
            r_valid <= 1'b1;
            r_data  <= r_len;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end

         if (clr) begin
            r_ovf <= 1'b0;
         end else if (w_load && r_valid && !w_drain) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign filt_out  = w_filt;
   assign evt_pulse = r_pulse;
   assign evt_count = r_cnt;
   assign sat       = r_sat;
   assign rpt_valid = r_valid;
   assign rpt_data  = r_data;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_and_event_monitor.sv
// Purpose: self-checking bench for and_event_monitor. Two instances (CNT_W=8
//          and CNT_W=4) share all inputs and are compared every cycle against
//          a history/timestamp based reference model, plus directed checks.
module tb_and_event_monitor;

   localparam int unsigned FL = 3;

   logic clk = 1'b0;
   logic rst, and_in, en, clr, rpt_ready;

   logic       filt8, pulse8, sat8, valid8, ovf8;
   logic [7:0] cnt8, data8;
   logic       filt4, pulse4, sat4, valid4, ovf4;
   logic [3:0] cnt4, data4;

   always #5 clk = ~clk;

   and_event_monitor #(.FILT_LEN(FL), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .and_in(and_in), .en(en), .clr(clr),
      .filt_out(filt8), .evt_pulse(pulse8), .evt_count(cnt8), .sat(sat8),
      .rpt_valid(valid8), .rpt_ready(rpt_ready), .rpt_data(data8), .ovf(ovf8)
   );

   and_event_monitor #(.FILT_LEN(FL), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .and_in(and_in), .en(en), .clr(clr),
      .filt_out(filt4), .evt_pulse(pulse4), .evt_count(cnt4), .sat(sat4),
      .rpt_valid(valid4), .rpt_ready(rpt_ready), .rpt_data(data4), .ovf(ovf4)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state; index 0 = 8-bit instance, 1 = 4-bit instance.
   bit m_filt;
   bit hist[$];
   int cyc      = 0;
   int rise_cyc = 0;
   bit m_armed;
   bit m_pulse;
   int m_cnt[2];
   bit m_sat[2];
   bit m_valid[2];
   int m_data[2];
   bit m_ovf[2];
   int maxv[2] = '{255, 15};

   // Observation statistics for directed checks (8-bit instance).
   int n_pulse = 0;
   int n_valid = 0;
   int last_data[2] = '{0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit nf, all_diff, rise, fall, load, drain;
      cyc++;
      if (rst) begin
         hist.delete();
         m_filt = 0; m_armed = 0; m_pulse = 0;
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_sat[k] = 0; m_valid[k] = 0; m_data[k] = 0; m_ovf[k] = 0;
         end
         return;
      end
      hist.push_back(and_in);
      if (hist.size() > FL) void'(hist.pop_front());
      nf = m_filt;
      if (hist.size() == FL) begin
         all_diff = 1;
         foreach (hist[i]) if (hist[i] == m_filt) all_diff = 0;
         if (all_diff) begin
            nf = and_in;
            hist.delete();
         end
      end
      rise = !m_filt && nf;
      fall = m_filt && !nf;
      m_pulse = rise && en;
      load = fall && m_armed && en;
      for (int k = 0; k < 2; k++) begin
         drain = m_valid[k] && rpt_ready;
         if (load) begin
            if (!m_valid[k] || drain) begin
               m_valid[k] = 1;
               m_data[k]  = (cyc - rise_cyc > maxv[k]) ? maxv[k] : cyc - rise_cyc;
            end else begin
               m_ovf[k] = 1;
            end
         end else if (drain) begin
            m_valid[k] = 0;
         end
         if (clr) begin
            m_cnt[k] = 0; m_sat[k] = 0; m_ovf[k] = 0;
         end else if (rise && en) begin
            if (m_cnt[k] == maxv[k]) m_sat[k] = 1;
            else m_cnt[k]++;
         end
      end
      if (rise) begin
         m_armed  = en;
         rise_cyc = cyc;
      end
      m_filt = nf;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("filt8",  filt8,  m_filt);
      chk("pulse8", pulse8, m_pulse);
      chk("cnt8",   cnt8,   m_cnt[0]);
      chk("sat8",   sat8,   m_sat[0]);
      chk("valid8", valid8, m_valid[0]);
      chk("data8",  data8,  m_data[0]);
      chk("ovf8",   ovf8,   m_ovf[0]);
      chk("filt4",  filt4,  m_filt);
      chk("pulse4", pulse4, m_pulse);
      chk("cnt4",   cnt4,   m_cnt[1]);
      chk("sat4",   sat4,   m_sat[1]);
      chk("valid4", valid4, m_valid[1]);
      chk("data4",  data4,  m_data[1]);
      chk("ovf4",   ovf4,   m_ovf[1]);
      if (pulse8) n_pulse++;
      if (valid8) begin n_valid++; last_data[0] = 32'(data8); end
      if (valid4) last_data[1] = 32'(data4);
   endtask

   task automatic drive(input bit a, input int n);
      and_in = a;
      for (int i = 0; i < n; i++) tick();
   endtask

   int p0, v0;

   initial begin
      rst = 1; and_in = 0; en = 1; clr = 0; rpt_ready = 1;

      // 1. reset, then release with and_in high
      drive(0, 2);
      chk("rst_cnt", cnt8, 0);
      chk("rst_valid", valid8, 0);
      drive(1, 1);
      rst = 0;
      drive(1, 2);
      chk("rel_filt_early", filt8, 0);
      drive(1, 1);
      chk("rel_filt", filt8, 1);
      chk("rel_cnt", cnt8, 1);
      drive(0, 6);

      // 2. glitch shorter than filter length
      clr = 1; tick(); clr = 0;
      p0 = n_pulse;
      drive(1, 2);
      drive(0, 6);
      chk("glitch_pulses", n_pulse - p0, 0);
      chk("glitch_cnt", cnt8, 0);

      // 3. clean pulse, then pulse with a 1-cycle dropout
      p0 = n_pulse; v0 = n_valid;
      drive(1, 10);
      drive(0, 8);
      chk("clean_pulses", n_pulse - p0, 1);
      chk("clean_cnt", cnt8, 1);
      chk("clean_valid_cycles", n_valid - v0, 1);
      chk("clean_data", last_data[0], 10);
      p0 = n_pulse;
      drive(1, 4); drive(0, 1); drive(1, 5);
      drive(0, 8);
      chk("dropout_pulses", n_pulse - p0, 1);
      chk("dropout_data", last_data[0], 10);

      // 4. backpressure
      rpt_ready = 0;
      clr = 1; tick(); clr = 0;
      drive(1, 5); drive(0, 8);
      drive(1, 7); drive(0, 8);
      chk("bp_data", data8, 5);
      chk("bp_ovf", ovf8, 1);
      chk("bp_valid", valid8, 1);
      rpt_ready = 1;
      tick();
      chk("bp_drain", valid8, 0);

      // 5. saturation on the 4-bit instance
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1, 4); drive(0, 5);
      end
      chk("sat_cnt4", cnt4, 15);
      chk("sat_sat4", sat4, 1);
      chk("sat_cnt8", cnt8, 16);
      chk("sat_sat8", sat8, 0);
      drive(1, 20); drive(0, 6);
      chk("sat_data4", last_data[1], 15);
      chk("sat_data8", last_data[0], 20);

      // 6a. clr on the same edge as a counted rise
      drive(1, 2);
      clr = 1; tick(); clr = 0;
      chk("clr_rise_cnt", cnt8, 0);
      chk("clr_rise_sat", sat4, 0);
      drive(0, 6);

      // 6b. reset in the middle of a high period
      v0 = n_valid;
      drive(1, 5);
      rst = 1; drive(0, 1); rst = 0;
      drive(0, 8);
      chk("rst_mid_valid", n_valid - v0, 0);

      // 6c. en low at rise, high at fall
      p0 = n_pulse; v0 = n_valid;
      en = 0; drive(1, 6);
      en = 1; drive(0, 8);
      chk("en_rise_pulses", n_pulse - p0, 0);
      chk("en_rise_cnt", cnt8, 0);
      chk("en_rise_valid", n_valid - v0, 0);

      // Randomized runs of and_in with random control inputs.
      for (int r = 0; r < 120; r++) begin
         int len;
         and_in = ~and_in;
         len = int'($urandom_range(1, 12));
         for (int j = 0; j < len; j++) begin
            en        = ($urandom % 8) != 0;
            rpt_ready = ($urandom % 3) != 0;
            clr       = ($urandom % 40) == 0;
            rst       = ($urandom % 200) == 0;
            tick();
         end
      end
      rst = 0; clr = 0; en = 1; rpt_ready = 1;
      drive(0, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
